// File: rtl/mem_arbiter_if.sv
// Request/response bundle between two requesters (CPU, external), the arbiter and the memory controller.
interface mem_arbiter_if;
  logic        cpu_read_en, cpu_write_en, cpu_dbl_byte_en;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err;

  logic        ext_read_en, ext_write_en, ext_dbl_byte_en;
  logic [15:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack, ext_err;

  logic        mem_read_en, mem_write_en, mem_dbl_byte_en;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        mem_ack;

  logic        grant_cpu, grant_ext, busy;

  modport slave (
    input  cpu_read_en, cpu_write_en, cpu_dbl_byte_en, cpu_addr, cpu_wdata,
    input  ext_read_en, ext_write_en, ext_dbl_byte_en, ext_addr, ext_wdata,
    input  mem_ack, mem_data_in,
    output cpu_ack, cpu_err, cpu_rdata, ext_ack, ext_err, ext_rdata,
    output mem_read_en, mem_write_en, mem_dbl_byte_en, mem_addr, mem_data_out,
    output grant_cpu, grant_ext, busy
  );

  modport master (
    output cpu_read_en, cpu_write_en, cpu_dbl_byte_en, cpu_addr, cpu_wdata,
    output ext_read_en, ext_write_en, ext_dbl_byte_en, ext_addr, ext_wdata,
    output mem_ack, mem_data_in,
    input  cpu_ack, cpu_err, cpu_rdata, ext_ack, ext_err, ext_rdata,
    input  mem_read_en, mem_write_en, mem_dbl_byte_en, mem_addr, mem_data_out,
    input  grant_cpu, grant_ext, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between CPU and external requester onto a single memory port,
// with a per-transaction timeout that aborts with an error and 16'hFFFF read data.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_d;
  logic            owner, owner_d, last_grant, last_grant_d;
  logic            wr, wr_d, dbl, dbl_d;
  logic [DW-1:0]   addr, addr_d, wdata, wdata_d;
  logic [CW-1:0]   cnt, cnt_d;

  logic            mem_read_en_q, mem_read_en_d, mem_write_en_q, mem_write_en_d;
  logic            mem_dbl_q, mem_dbl_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d, mem_data_out_q, mem_data_out_d;
  logic            cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic            ext_ack_q, ext_ack_d, ext_err_q, ext_err_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d, ext_rdata_q, ext_rdata_d;
  logic            grant_cpu_q, grant_cpu_d, grant_ext_q, grant_ext_d, busy_q, busy_d;

  logic            cpu_req, ext_req, pick_ext, timeout_hit, fin_ok, fin_err, fin;

  // Next-state, latched-request and registered-output computation
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    wr_d         = wr;
    dbl_d        = dbl;
    addr_d       = addr;
    wdata_d      = wdata;
    cnt_d        = cnt;
    fin_ok       = 1'b0;
    fin_err      = 1'b0;

    cpu_req     = bus.cpu_read_en | bus.cpu_write_en;
    ext_req     = bus.ext_read_en | bus.ext_write_en;
    pick_ext    = ext_req & (~cpu_req | (last_grant == OWN_CPU));
    timeout_hit = ((9'({1'b0, cnt}) + 9'd1) == 9'(TIMEOUT));

    case (state)
      IDLE: begin
        if (cpu_req || ext_req) begin
          state_d      = BUSY;
          owner_d      = pick_ext;
          last_grant_d = pick_ext;
          cnt_d        = '0;
          if (pick_ext) begin
            wr_d    = bus.ext_write_en;
            dbl_d   = bus.ext_dbl_byte_en;
            addr_d  = bus.ext_addr;
            wdata_d = bus.ext_wdata;
          end else begin
            wr_d    = bus.cpu_write_en;
            dbl_d   = bus.cpu_dbl_byte_en;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt + CW'(1);
        // A late ack in the timeout cycle still wins over the abort
        if (bus.mem_ack) begin
          state_d = DONE;
          fin_ok  = 1'b1;
        end else if (timeout_hit) begin
          state_d = DONE;
          fin_err = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    fin            = fin_ok | fin_err;
    busy_d         = (state_d == BUSY);
    mem_read_en_d  = busy_d & ~wr_d;
    mem_write_en_d = busy_d & wr_d;
    mem_dbl_d      = busy_d & dbl_d;
    mem_addr_d     = busy_d ? addr_d  : '0;
    mem_data_out_d = busy_d ? wdata_d : '0;
    grant_cpu_d    = (state_d != IDLE) && (owner_d == OWN_CPU);
    grant_ext_d    = (state_d != IDLE) && (owner_d == OWN_EXT);
    cpu_ack_d      = fin & (owner == OWN_CPU);
    cpu_err_d      = fin_err & (owner == OWN_CPU);
    ext_ack_d      = fin & (owner == OWN_EXT);
    ext_err_d      = fin_err & (owner == OWN_EXT);

    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    if (owner == OWN_CPU) begin
      if (fin_err)          cpu_rdata_d = 16'hFFFF;
      else if (fin_ok & ~wr) cpu_rdata_d = bus.mem_data_in;
    end else begin
      if (fin_err)          ext_rdata_d = 16'hFFFF;
      else if (fin_ok & ~wr) ext_rdata_d = bus.mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= OWN_CPU;
      last_grant     <= OWN_EXT;
      wr             <= 1'b0;
      dbl            <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      cnt            <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_dbl_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      cpu_ack_q      <= 1'b0;
      cpu_err_q      <= 1'b0;
      ext_ack_q      <= 1'b0;
      ext_err_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      ext_rdata_q    <= '0;
      grant_cpu_q    <= 1'b0;
      grant_ext_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_d;
      owner          <= owner_d;
      last_grant     <= last_grant_d;
      wr             <= wr_d;
      dbl            <= dbl_d;
      addr           <= addr_d;
      wdata          <= wdata_d;
      cnt            <= cnt_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_dbl_q      <= mem_dbl_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      cpu_ack_q      <= cpu_ack_d;
      cpu_err_q      <= cpu_err_d;
      ext_ack_q      <= ext_ack_d;
      ext_err_q      <= ext_err_d;
      cpu_rdata_q    <= cpu_rdata_d;
      ext_rdata_q    <= ext_rdata_d;
      grant_cpu_q    <= grant_cpu_d;
      grant_ext_q    <= grant_ext_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.mem_read_en     = mem_read_en_q;
  assign bus.mem_write_en    = mem_write_en_q;
  assign bus.mem_dbl_byte_en = mem_dbl_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_data_out    = mem_data_out_q;
  assign bus.cpu_ack         = cpu_ack_q;
  assign bus.cpu_err         = cpu_err_q;
  assign bus.cpu_rdata       = cpu_rdata_q;
  assign bus.ext_ack         = ext_ack_q;
  assign bus.ext_err         = ext_err_q;
  assign bus.ext_rdata       = ext_rdata_q;
  assign bus.grant_cpu       = grant_cpu_q;
  assign bus.grant_ext       = grant_ext_q;
  assign bus.busy            = busy_q;
endmodule
